// File: rtl/console_pkg.sv
// Shared character codes and FSM state encoding for the byte-stream text console.
package console_pkg;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_SCREEN
  } state_t;

endpackage

// File: rtl/console_clear_seq.sv
// Column/row sweep counter that supplies blanking addresses for a single line or the
// whole screen; done flags the final cell of the current sweep.
module console_clear_seq #(
  parameter int COLS     = 160,
  parameter int ROWS     = 64,
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 6
) (
  input  logic                clk48,
  input  logic                rst_n,
  input  logic                start_line,
  input  logic                start_screen,
  input  logic [ROW_BITS-1:0] line_row,
  input  logic                step,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                done
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  logic line_mode;

  // Reset leaves the counter at (0,0) in screen mode, ready for a clear-on-reset sweep.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      line_mode <= 1'b0;
    end else if (start_screen) begin
      col       <= '0;
      row       <= '0;
      line_mode <= 1'b0;
    end else if (start_line) begin
      col       <= '0;
      row       <= line_row;
      line_mode <= 1'b1;
    end else if (step) begin
      if (col == LAST_COL) begin
        col <= '0;
        if (!line_mode) row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign done = (col == LAST_COL) && (line_mode || (row == LAST_ROW));

endmodule

// File: rtl/text_console.sv
// Text terminal front end: consumes a valid/ready byte stream, writes printable bytes at
// the cursor into the VGA text RAM and interprets CR, LF, BS, TAB and FF.
module text_console
  import console_pkg::*;
#(
  parameter int         COLS           = 160,
  parameter int         ROWS           = 64,
  parameter int         COL_BITS       = 8,
  parameter int         ROW_BITS       = 6,
  parameter int         TAB_WIDTH      = 8,
  parameter logic [7:0] BLANK_CHAR     = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                         clk48,
  input  logic                         rst_n,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ROW_BITS+COL_BITS-1:0] vga_waddr,
  output logic [7:0]                   vga_wdata,
  output logic                         vga_wr_en,
  output logic [COL_BITS-1:0]          cursor_col,
  output logic [ROW_BITS-1:0]          cursor_row,
  output logic                         busy
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS:0]   TAB_MASK = (COL_BITS + 1)'(TAB_WIDTH - 1);
  localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS + 1)'(COLS);

  // Handshake: a byte transfers on every rising clk48 edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and the producer must hold in_data stable until then.
  state_t state;

  logic                accept, printable, newline_evt, tab_wrap;
  logic [COL_BITS:0]   tab_next;
  logic [ROW_BITS-1:0] next_row;
  logic [COL_BITS-1:0] clr_col;
  logic [ROW_BITS-1:0] clr_row;
  logic                clr_done;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    printable   = (in_data >= 8'h20) && (in_data != CH_DEL);
    next_row    = (cursor_row == LAST_ROW) ? '0 : cursor_row + 1'b1;
    tab_next    = ({1'b0, cursor_col} | TAB_MASK) + 1'b1;
    tab_wrap    = (tab_next >= COLS_W);
    newline_evt = (printable && (cursor_col == LAST_COL)) ||
                  (in_data == CH_LF) ||
                  ((in_data == CH_TAB) && tab_wrap);
  end

  console_clear_seq #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS)
  ) u_clear_seq (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .start_line   (accept && newline_evt),
    .start_screen (accept && (in_data == CH_FF)),
    .line_row     (next_row),
    .step         (state != ST_IDLE),
    .col          (clr_col),
    .row          (clr_row),
    .done         (clr_done)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? ST_CLR_SCREEN : ST_IDLE;
      busy       <= CLEAR_ON_RESET;
      cursor_col <= '0;
      cursor_row <= '0;
      vga_wr_en  <= 1'b0;
      vga_waddr  <= '0;
      vga_wdata  <= '0;
    end else begin
      vga_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (printable) begin
              vga_wr_en <= 1'b1;
              vga_waddr <= {cursor_row, cursor_col};
              vga_wdata <= in_data;
            end
            // Newline (explicit, wrap or TAB overflow) moves down and blanks the new row.
            if (newline_evt) begin
              cursor_col <= '0;
              cursor_row <= next_row;
              state      <= ST_CLR_LINE;
              busy       <= 1'b1;
            end else if (printable) begin
              cursor_col <= cursor_col + 1'b1;
            end else begin
              case (in_data)
                CH_CR:  cursor_col <= '0;
                CH_BS:  if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
                CH_TAB: cursor_col <= tab_next[COL_BITS-1:0];
                CH_FF: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  state      <= ST_CLR_SCREEN;
                  busy       <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CLR_LINE, ST_CLR_SCREEN: begin
          vga_wr_en <= 1'b1;
          vga_waddr <= {clr_row, clr_col};
          vga_wdata <= BLANK_CHAR;
          if (clr_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a 4x2 console with clear-on-reset and a 160x64 console
// without it, checked against hand-computed write sequences and cursor positions.
module tb_text_console;

  logic        clk48 = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  in_data_a = '0, in_data_b = '0;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic        in_ready_a, in_ready_b;
  logic [13:0] waddr_a, waddr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        wr_en_a, wr_en_b;
  logic [7:0]  col_a, col_b;
  logic [5:0]  row_a, row_b;
  logic        busy_a, busy_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [21:0] wr_q[$];
  logic [21:0] exp_q[$];
  int          wr_cyc_q[$];
  int          b_wr_cnt = 0;
  int          b_blank_r1 = 0;

  text_console #(.COLS(4), .ROWS(2), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk48(clk48), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .vga_waddr(waddr_a), .vga_wdata(wdata_a), .vga_wr_en(wr_en_a),
    .cursor_col(col_a), .cursor_row(row_a), .busy(busy_a)
  );

  text_console #(.COLS(160), .ROWS(64), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk48(clk48), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .vga_waddr(waddr_b), .vga_wdata(wdata_b), .vga_wr_en(wr_en_b),
    .cursor_col(col_b), .cursor_row(row_b), .busy(busy_b)
  );

  // clock/reset block
  always #5 clk48 = ~clk48;
  always @(posedge clk48) cyc++;

  // write monitors
  always @(negedge clk48) begin
    if (wr_en_a) begin
      wr_q.push_back({waddr_a, wdata_a});
      wr_cyc_q.push_back(cyc);
    end
    if (wr_en_b) begin
      b_wr_cnt++;
      if (waddr_b[13:8] == 6'd1 && wdata_b == 8'h20) b_blank_r1++;
    end
  end

  // driver tasks: entered and left just after a rising edge
  task automatic send_a(input logic [7:0] b, output int stall);
    in_data_a  = b;
    in_valid_a = 1'b1;
    stall = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk48);
      if (in_ready_a) break;
      stall++;
    end
    if (!in_ready_a) begin
      total_cnt++;
      $display("FAIL send_a_timeout byte=%02h in_ready never rose", b);
    end
    @(posedge clk48);
    #1;
  endtask

  task automatic send_b(input logic [7:0] b);
    in_data_b  = b;
    in_valid_b = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk48);
      if (in_ready_b) break;
    end
    if (!in_ready_b) begin
      total_cnt++;
      $display("FAIL send_b_timeout byte=%02h in_ready never rose", b);
    end
    @(posedge clk48);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic wait_ready_a(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk48);
      if (in_ready_a) break;
    end
    total_cnt++;
    if (in_ready_a !== 1'b1) $display("FAIL wait_ready_a got=%b want=1", in_ready_a);
    else pass_cnt++;
    @(posedge clk48);
    #1;
  endtask

  task automatic push_blank_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back({6'(r), 8'(c), 8'h20});
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk48);
    total_cnt++; if (wr_en_a !== 1'b0) $display("FAIL rst_wr_en got=%b want=0", wr_en_a); else pass_cnt++;
    total_cnt++; if (waddr_a !== 14'd0) $display("FAIL rst_waddr got=%h want=0", waddr_a); else pass_cnt++;
    total_cnt++; if (wdata_a !== 8'd0) $display("FAIL rst_wdata got=%h want=0", wdata_a); else pass_cnt++;
    total_cnt++; if ({row_a, col_a} !== 14'd0) $display("FAIL rst_cursor got=%h want=0", {row_a, col_a}); else pass_cnt++;
    total_cnt++; if (in_ready_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL rst_a_state got ready=%b busy=%b want 0/1", in_ready_a, busy_a); else pass_cnt++;
    total_cnt++; if (in_ready_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL rst_b_state got ready=%b busy=%b want 1/0", in_ready_b, busy_b); else pass_cnt++;
    @(posedge clk48);
    #1;
    rst_n = 1'b1;
    wr_q.delete();
    exp_q.delete();
    wait_ready_a(50);
    push_blank_rows(0, 1);
    total_cnt++; if (wr_q.size() != 8) $display("FAIL rst_clear_count got=%0d want=8", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) $display("FAIL rst_clear_write[%0d] got=%h want=%h", i, (i < wr_q.size()) ? wr_q[i] : 22'h0, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if ({row_a, col_a} !== 14'd0) $display("FAIL rst_cursor_after got=%h want=0", {row_a, col_a}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    wr_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
    send_a(8'h41, s0);
    send_a(8'h42, s1);
    idle(2);
    exp_q.push_back({6'd0, 8'd0, 8'h41});
    exp_q.push_back({6'd0, 8'd1, 8'h42});
    total_cnt++; if (s1 != 0) $display("FAIL b2b_bubble got=%0d want=0", s1); else pass_cnt++;
    total_cnt++; if (wr_q.size() != 2) $display("FAIL b2b_count got=%0d want=2", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) $display("FAIL b2b_write[%0d] got=%h want=%h", i, (i < wr_q.size()) ? wr_q[i] : 22'h0, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (wr_cyc_q.size() < 2 || wr_cyc_q[1] - wr_cyc_q[0] != 1) $display("FAIL b2b_consecutive got_gap=%0d want=1", (wr_cyc_q.size() < 2) ? -1 : wr_cyc_q[1] - wr_cyc_q[0]);
    else pass_cnt++;
    total_cnt++; if (col_a !== 8'd2 || row_a !== 6'd0) $display("FAIL b2b_cursor got=(%0d,%0d) want=(0,2)", row_a, col_a); else pass_cnt++;
  endtask

  task automatic test_wrap_hold();
    int s, sq;
    wr_q.delete();
    exp_q.delete();
    send_a(8'h0A, s);
    send_a(8'h57, s);
    send_a(8'h58, s);
    send_a(8'h59, s);
    send_a(8'h5A, s);
    send_a(8'h51, sq);
    idle(3);
    push_blank_rows(1, 1);
    exp_q.push_back({6'd1, 8'd0, 8'h57});
    exp_q.push_back({6'd1, 8'd1, 8'h58});
    exp_q.push_back({6'd1, 8'd2, 8'h59});
    exp_q.push_back({6'd1, 8'd3, 8'h5A});
    push_blank_rows(0, 0);
    exp_q.push_back({6'd0, 8'd0, 8'h51});
    total_cnt++; if (sq != 4) $display("FAIL wrap_ready_low got=%0d want=4", sq); else pass_cnt++;
    total_cnt++; if (wr_q.size() != 13) $display("FAIL wrap_count got=%0d want=13", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) $display("FAIL wrap_write[%0d] got=%h want=%h", i, (i < wr_q.size()) ? wr_q[i] : 22'h0, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (col_a !== 8'd1 || row_a !== 6'd0) $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,1)", row_a, col_a); else pass_cnt++;
  endtask

  task automatic test_tab();
    int cnt0, n;
    for (int i = 0; i < 5; i++) send_b(8'h61);
    idle(2);
    total_cnt++; if (col_b !== 8'd5) $display("FAIL tab_pre_col got=%0d want=5", col_b); else pass_cnt++;
    cnt0 = b_wr_cnt;
    send_b(8'h09);
    idle(2);
    total_cnt++; if (col_b !== 8'd8 || row_b !== 6'd0) $display("FAIL tab_col got=(%0d,%0d) want=(0,8)", row_b, col_b); else pass_cnt++;
    total_cnt++; if (b_wr_cnt != cnt0) $display("FAIL tab_no_write got=%0d want=%0d", b_wr_cnt, cnt0); else pass_cnt++;
    for (int i = 0; i < 149; i++) send_b(8'h62);
    idle(2);
    total_cnt++; if (col_b !== 8'd157) $display("FAIL tab_col157 got=%0d want=157", col_b); else pass_cnt++;
    cnt0 = b_wr_cnt;
    b_blank_r1 = 0;
    send_b(8'h09);
    in_valid_b = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk48);
      if (i == 0) begin
        total_cnt++;
        if (busy_b !== 1'b1 || col_b !== 8'd0 || row_b !== 6'd1) $display("FAIL tab_wrap_state got busy=%b (%0d,%0d) want busy=1 (1,0)", busy_b, row_b, col_b);
        else pass_cnt++;
      end
      if (in_ready_b) break;
      n++;
    end
    idle(1);
    total_cnt++; if (n != 160) $display("FAIL tab_wrap_busy_cycles got=%0d want=160", n); else pass_cnt++;
    total_cnt++; if (b_blank_r1 != 160 || b_wr_cnt - cnt0 != 160) $display("FAIL tab_wrap_blanks got=%0d/%0d want=160/160", b_blank_r1, b_wr_cnt - cnt0); else pass_cnt++;
  endtask

  task automatic test_controls();
    int s;
    send_a(8'h08, s);
    idle(1);
    total_cnt++; if (col_a !== 8'd0) $display("FAIL bs_col got=%0d want=0", col_a); else pass_cnt++;
    send_a(8'h08, s);
    idle(1);
    total_cnt++; if (col_a !== 8'd0) $display("FAIL bs_at_zero got=%0d want=0", col_a); else pass_cnt++;
    send_a(8'h61, s);
    send_a(8'h62, s);
    send_a(8'h63, s);
    idle(2);
    total_cnt++; if (col_a !== 8'd3) $display("FAIL cr_pre_col got=%0d want=3", col_a); else pass_cnt++;
    wr_q.delete();
    send_a(8'h0D, s);
    idle(2);
    total_cnt++; if (col_a !== 8'd0 || row_a !== 6'd0) $display("FAIL cr_cursor got=(%0d,%0d) want=(0,0)", row_a, col_a); else pass_cnt++;
    send_a(8'h61, s);
    idle(2);
    wr_q.delete();
    send_a(8'h07, s);
    send_a(8'h7F, s);
    send_a(8'h08, s);
    send_a(8'h08, s);
    idle(2);
    total_cnt++; if (wr_q.size() != 0) $display("FAIL ctrl_no_write got=%0d want=0", wr_q.size()); else pass_cnt++;
    total_cnt++; if (col_a !== 8'd0 || row_a !== 6'd0 || in_ready_a !== 1'b1) $display("FAIL ctrl_cursor got=(%0d,%0d) ready=%b want=(0,0) 1", row_a, col_a, in_ready_a); else pass_cnt++;
  endtask

  task automatic test_form_feed();
    int s;
    send_a(8'h78, s);
    send_a(8'h79, s);
    idle(2);
    wr_q.delete();
    exp_q.delete();
    send_a(8'h0C, s);
    idle(12);
    push_blank_rows(0, 1);
    total_cnt++; if (wr_q.size() != 8) $display("FAIL ff_count got=%0d want=8", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) $display("FAIL ff_write[%0d] got=%h want=%h", i, (i < wr_q.size()) ? wr_q[i] : 22'h0, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if ({row_a, col_a} !== 14'd0 || in_ready_a !== 1'b1) $display("FAIL ff_cursor got=%h ready=%b want=0 1", {row_a, col_a}, in_ready_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    int s;
    send_a(8'h0C, s);
    in_valid_a = 1'b0;
    repeat (3) @(negedge clk48);
    total_cnt++; if (wr_en_a !== 1'b1 || busy_a !== 1'b1) $display("FAIL midclr_active got wr_en=%b busy=%b want 1/1", wr_en_a, busy_a); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (wr_en_a !== 1'b0) $display("FAIL midclr_wr_en got=%b want=0", wr_en_a); else pass_cnt++;
    total_cnt++; if (waddr_a !== 14'd0 || wdata_a !== 8'd0) $display("FAIL midclr_outputs got addr=%h data=%h want 0/0", waddr_a, wdata_a); else pass_cnt++;
    @(posedge clk48);
    #1;
    rst_n = 1'b1;
    wr_q.delete();
    exp_q.delete();
    wait_ready_a(50);
    push_blank_rows(0, 1);
    total_cnt++; if (wr_q.size() != 8) $display("FAIL restart_count got=%0d want=8", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) $display("FAIL restart_write[%0d] got=%h want=%h", i, (i < wr_q.size()) ? wr_q[i] : 22'h0, exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap_hold();
    test_tab();
    test_controls();
    test_form_feed();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
